multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multicycle control unit for the RV64 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU stage code `sel`, `ALUSrc` and `ALU_control_lines`, plus the PC, IR, memory and register-file enables.
- Sits beside the datapath; it is the only driver of `sel`, and the ALU evaluates only when `sel`=2.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for `mem_ready` in FETCH/MEM before entering TRAP (4-bit counter).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; leave IDLE and begin fetching while high
- instr  input  32  instruction word from memory, valid when `mem_ready`=1 in FETCH
- mem_ready  input  1  memory access complete this cycle
- zero  input  1  ALU zero flag, sampled in EXECUTE
- sel  output  3  stage code: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WB, 5 IDLE, 7 TRAP
- ALU_control_lines  output  4  ALU operation
- ALUSrc  output  2  00 register, 11 immediate, 10 PC+4 (jal)
- IRWrite  output  1  latch instruction register
- PCWrite  output  1  PC <= PC+4
- PCWriteCond  output  1  PC <= branch/jal target
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- RegWrite  output  1  register-file write
- MemtoReg  output  1  writeback source is memory data
- retired  output  1  one-cycle pulse on instruction completion
- illegal  output  1  sticky; set on entering TRAP

Behaviour:
- Reset (synchronous, highest priority, also mid-instruction):
  - State to IDLE, `sel`=5.
  - All other outputs 0, including `illegal`; internal IR copy and timeout counter cleared.
- IDLE: stays while `run`=0; goes to FETCH when `run`=1.
- FETCH (`sel`=0):
  - Outputs: `MemRead`=1.
  - On `mem_ready`=1: `IRWrite`=1 and `PCWrite`=1 for that cycle, capture `instr`, go to DECODE.
  - Otherwise wait; the counter increments each waiting cycle and reaching MEM_TIMEOUT goes to TRAP.
- DECODE (`sel`=1):
  - Classify opcode[6:0] as R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111.
  - Any other opcode, or an undefined funct3/funct7 combination, goes to TRAP.
- EXECUTE (`sel`=2), `ALU_control_lines`:
  - R-type: add 0001, sub 0000 (funct7=0100000), and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111.
  - I-type: addi 1001, andi 1010, ori 1011, xori 1100, slli 0101, srli 0110, srai 0111.
  - LOAD/STORE: 1001.
  - BRANCH: 0000.
  - JAL: 0001.
- EXECUTE, `ALUSrc`: 00 for R and BRANCH; 11 for I, LOAD, STORE; 10 for JAL.
- EXECUTE, next state:
  - BRANCH: taken when (funct3=000 && `zero`) or (funct3=001 && !`zero`); `PCWriteCond`=1 when taken; then FETCH with a `retired` pulse.
  - JAL: `PCWriteCond`=1, then WB.
  - LOAD/STORE go to MEM; R and I go to WB.
- MEM (`sel`=3):
  - LOAD asserts `MemRead`; STORE asserts `MemWrite`. Both are held until `mem_ready`.
  - LOAD then goes to WB.
  - STORE then goes to FETCH with `retired` (or IDLE if `run`=0).
  - Same MEM_TIMEOUT rule as FETCH.
- WB (`sel`=4):
  - `RegWrite`=1; `MemtoReg`=1 only for LOAD; `retired`=1.
  - Next FETCH if `run`=1, else IDLE.
- `ALU_control_lines` and `ALUSrc` hold their EXECUTE values through MEM/WB; they are 0 in IDLE, FETCH and TRAP.
- Writes to rd=x0 still assert `RegWrite`; the register file discards them.
- `run` deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- TRAP (`sel`=7): `illegal`=1, all enables 0; exits only by reset.
- Latency with zero memory wait: BRANCH 3 cycles, R/I/JAL/STORE 4, LOAD 5.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined:
  - Adds outputs `cycle_cnt[63:0]` (increments every non-IDLE, non-TRAP cycle) and `instret_cnt[63:0]` (increments on `retired`).
  - Both reset to 0 and wrap modulo 2^64.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then `run`=1, `mem_ready`=1, `instr`=0x002081B3 (add) -> `sel` 0,1,2,4; `ALU_control_lines`=0001 and `ALUSrc`=00 in EXECUTE; `RegWrite`=1 and `retired`=1 at cycle 4.
- `instr`=0x00500093 (addi) -> `ALUSrc`=11, `ALU_control_lines`=1001; 4 cycles.
- `instr`=0x00208463 (beq) with `zero`=1 -> `PCWriteCond`=1 in EXECUTE; back to FETCH after 3 cycles. With `zero`=0 -> `PCWriteCond`=0.
- `instr`=0x0000A283 (lw) with `mem_ready` low for 3 MEM cycles -> `MemRead` held 4 cycles; WB asserts `MemtoReg`=1 and `RegWrite`=1. `instr`=0x0050A223 (sw) -> `MemWrite`=1, no WB.
- `instr`=0xFFFFFFFF -> TRAP after DECODE, `sel`=7, `illegal`=1 held. `mem_ready` held 0 in FETCH for 15 cycles -> TRAP.
- `reset` asserted during MEM of lw -> next cycle `sel`=5 and all enables 0. With MULTICYCLE_PERF_EN, after add + beq: `instret_cnt`=2 and `cycle_cnt`=7.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake bundle between the multicycle controller (master) and the RV64 datapath (slave).
interface multicycle_ctrl_fsm_if;
  logic        run;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  sel;
  logic [3:0]  ALU_control_lines;
  logic [1:0]  ALUSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        retired;
  logic        illegal;

  modport master (
    input  run, instr, mem_ready, zero,
    output sel, ALU_control_lines, ALUSrc, IRWrite, PCWrite, PCWriteCond,
           MemRead, MemWrite, RegWrite, MemtoReg, retired, illegal
  );

  modport slave (
    output run, instr, mem_ready, zero,
    input  sel, ALU_control_lines, ALUSrc, IRWrite, PCWrite, PCWriteCond,
           MemRead, MemWrite, RegWrite, MemtoReg, retired, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV64 control unit: FETCH -> DECODE -> EXECUTE -> MEM -> WB with memory timeout trap.
// Optional macro MULTICYCLE_PERF_EN adds 64-bit cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_fsm_if.master bus
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  // Encodings double as the externally visible stage code on sel.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_IDLE    = 3'd5,
    S_TRAP    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6
  } cls_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [3:0] WAIT_LAST  = 4'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_opcode;
  logic [2:0] r_funct3;
  logic [6:0] r_funct7;
  logic [3:0] r_wait_cnt;
  logic       r_illegal;

  cls_t       w_cls;
  logic [3:0] w_alu_op;
  logic [1:0] w_alu_src;
  logic       w_wait_last;
  logic       w_taken;
  state_t     w_after_retire;

  logic [3:0] w_alu_ctrl;
  logic [1:0] w_alu_sel;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_retired;

  // Instruction classification from the latched opcode/funct fields.
  always_comb begin
    w_cls     = CLS_NONE;
    w_alu_op  = 4'b0000;
    w_alu_src = 2'b00;
    case (r_opcode)
      OPC_R: begin
        if (r_funct7 == 7'b0000000) begin
          w_cls = CLS_R;
          case (r_funct3)
            3'b000:  w_alu_op = 4'b0001;
            3'b111:  w_alu_op = 4'b0010;
            3'b110:  w_alu_op = 4'b0011;
            3'b100:  w_alu_op = 4'b0100;
            3'b001:  w_alu_op = 4'b0101;
            3'b101:  w_alu_op = 4'b0110;
            default: w_cls    = CLS_NONE;
          endcase
        end else if (r_funct7 == 7'b0100000) begin
          w_cls = CLS_R;
          case (r_funct3)
            3'b000:  w_alu_op = 4'b0000;
            3'b101:  w_alu_op = 4'b0111;
            default: w_cls    = CLS_NONE;
          endcase
        end
      end
      OPC_I: begin
        // RV64 shift immediates carry a 6-bit shamt, so only imm[11:6] qualifies the shift.
        w_cls     = CLS_I;
        w_alu_src = 2'b11;
        case (r_funct3)
          3'b000: w_alu_op = 4'b1001;
          3'b111: w_alu_op = 4'b1010;
          3'b110: w_alu_op = 4'b1011;
          3'b100: w_alu_op = 4'b1100;
          3'b001: begin
            if (r_funct7[6:1] == 6'b000000) w_alu_op = 4'b0101;
            else                            w_cls    = CLS_NONE;
          end
          3'b101: begin
            if (r_funct7[6:1] == 6'b000000)      w_alu_op = 4'b0110;
            else if (r_funct7[6:1] == 6'b010000) w_alu_op = 4'b0111;
            else                                 w_cls    = CLS_NONE;
          end
          default: w_cls = CLS_NONE;
        endcase
      end
      OPC_LOAD: begin
        if (r_funct3 != 3'b111) begin
          w_cls     = CLS_LOAD;
          w_alu_op  = 4'b1001;
          w_alu_src = 2'b11;
        end
      end
      OPC_STORE: begin
        if (!r_funct3[2]) begin
          w_cls     = CLS_STORE;
          w_alu_op  = 4'b1001;
          w_alu_src = 2'b11;
        end
      end
      OPC_BRANCH: begin
        if (r_funct3[2:1] == 2'b00) begin
          w_cls     = CLS_BRANCH;
          w_alu_op  = 4'b0000;
          w_alu_src = 2'b00;
        end
      end
      OPC_JAL: begin
        w_cls     = CLS_JAL;
        w_alu_op  = 4'b0001;
        w_alu_src = 2'b10;
      end
      default: w_cls = CLS_NONE;
    endcase
  end

  assign w_wait_last    = (r_wait_cnt == WAIT_LAST);
  assign w_taken        = ((r_funct3 == 3'b000) && bus.zero) ||
                          ((r_funct3 == 3'b001) && !bus.zero);
  assign w_after_retire = bus.run ? S_FETCH : S_IDLE;

  // Next state and control outputs.
  always_comb begin
    w_next          = r_state;
    w_alu_ctrl      = 4'b0000;
    w_alu_sel       = 2'b00;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_retired       = 1'b0;

    if ((r_state == S_EXECUTE) || (r_state == S_MEM) || (r_state == S_WB)) begin
      w_alu_ctrl = w_alu_op;
      w_alu_sel  = w_alu_src;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.run) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_wait_last) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_next = (w_cls == CLS_NONE) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (w_cls)
          CLS_BRANCH: begin
            w_pc_write_cond = w_taken;
            w_retired       = 1'b1;
            w_next          = w_after_retire;
          end
          CLS_JAL: begin
            w_pc_write_cond = 1'b1;
            w_next          = S_WB;
          end
          CLS_LOAD, CLS_STORE: w_next = S_MEM;
          CLS_R, CLS_I:        w_next = S_WB;
          default:             w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        w_mem_read  = (w_cls == CLS_LOAD);
        w_mem_write = (w_cls == CLS_STORE);
        if (bus.mem_ready) begin
          if (w_cls == CLS_LOAD) begin
            w_next = S_WB;
          end else begin
            w_retired = 1'b1;
            w_next    = w_after_retire;
          end
        end else if (w_wait_last) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_cls == CLS_LOAD);
        w_retired    = 1'b1;
        w_next       = w_after_retire;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7   <= 7'd0;
      r_wait_cnt <= 4'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_write) begin
        r_opcode <= bus.instr[6:0];
        r_funct3 <= bus.instr[14:12];
        r_funct7 <= bus.instr[31:25];
      end
      // Counter runs only while parked in FETCH/MEM; any transition restarts it.
      if ((w_next == r_state) && ((r_state == S_FETCH) || (r_state == S_MEM)))
        r_wait_cnt <= r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= 4'd0;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  assign bus.sel               = r_state;
  assign bus.ALU_control_lines = w_alu_ctrl;
  assign bus.ALUSrc            = w_alu_sel;
  assign bus.IRWrite           = w_ir_write;
  assign bus.PCWrite           = w_pc_write;
  assign bus.PCWriteCond       = w_pc_write_cond;
  assign bus.MemRead           = w_mem_read;
  assign bus.MemWrite          = w_mem_write;
  assign bus.RegWrite          = w_reg_write;
  assign bus.MemtoReg          = w_mem_to_reg;
  assign bus.retired           = w_retired;
  assign bus.illegal           = r_illegal;

`ifdef MULTICYCLE_PERF_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (w_retired) r_instret_cnt <= r_instret_cnt + 64'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-instruction stage sequences predicted from the ISA rules.
module tb_multicycle_ctrl_fsm;
  localparam int MEM_TIMEOUT = 15;
  localparam int K_TRAP = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_JAL = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_ctrl_fsm_if bus();
`ifdef MULTICYCLE_PERF_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
`endif

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] alu;
    logic [1:0] src;
    logic irw, pcw, pcwc, mr, mw, rw, m2r, ret, ill;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   in_idle = 1'b1;

  function automatic exp_t mk(input logic [2:0] sel);
    exp_t e;
    e = '0;
    e.sel = sel;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.sel  = bus.sel;
    a.alu  = bus.ALU_control_lines;
    a.src  = bus.ALUSrc;
    a.irw  = bus.IRWrite;
    a.pcw  = bus.PCWrite;
    a.pcwc = bus.PCWriteCond;
    a.mr   = bus.MemRead;
    a.mw   = bus.MemWrite;
    a.rw   = bus.RegWrite;
    a.m2r  = bus.MemtoReg;
    a.ret  = bus.retired;
    a.ill  = bus.illegal;
    return a;
  endfunction

  // Monitor: one expected vector per presented cycle.
  initial begin
    forever begin : mon
      exp_t e, a;
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = observed();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_outputs t=%0t got sel=%0d alu=%b src=%b irw/pcw/pcwc/mr/mw/rw/m2r/ret/ill=%b expected sel=%0d alu=%b src=%b flags=%b",
                   $time, a.sel, a.alu, a.src, a[8:0], e.sel, e.alu, e.src, e[8:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic drive(input bit run, input bit rdy, input logic [31:0] ins, input bit z);
    bus.run       = run;
    bus.mem_ready = rdy;
    bus.instr     = ins;
    bus.zero      = z;
  endtask

  task automatic noise(input bit run);
    drive(run, rb(), $urandom(), rb());
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reference ISA classification: class, ALU op and operand source.
  function automatic void ref_decode(input logic [31:0] ins, output int cls,
                                     output logic [3:0] alu, output logic [1:0] src);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    cls = K_TRAP;
    alu = 4'd0;
    src = 2'd0;
    case (ins[6:0])
      7'b0110011: begin
        src = 2'b00;
        if (f7 == 7'h00) begin
          cls = K_R;
          case (f3)
            3'd0: alu = 4'b0001;
            3'd7: alu = 4'b0010;
            3'd6: alu = 4'b0011;
            3'd4: alu = 4'b0100;
            3'd1: alu = 4'b0101;
            3'd5: alu = 4'b0110;
            default: cls = K_TRAP;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          cls = K_R; alu = 4'b0000;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          cls = K_R; alu = 4'b0111;
        end
      end
      7'b0010011: begin
        src = 2'b11;
        cls = K_I;
        case (f3)
          3'd0: alu = 4'b1001;
          3'd7: alu = 4'b1010;
          3'd6: alu = 4'b1011;
          3'd4: alu = 4'b1100;
          3'd1: if (ins[31:26] == 6'd0) alu = 4'b0101; else cls = K_TRAP;
          3'd5: begin
            if (ins[31:26] == 6'd0)            alu = 4'b0110;
            else if (ins[31:26] == 6'b010000) alu = 4'b0111;
            else                               cls = K_TRAP;
          end
          default: cls = K_TRAP;
        endcase
      end
      7'b0000011: if (f3 != 3'd7) begin cls = K_LD; alu = 4'b1001; src = 2'b11; end
      7'b0100011: if (f3 < 3'd4)  begin cls = K_ST; alu = 4'b1001; src = 2'b11; end
      7'b1100011: if (f3 < 3'd2)  begin cls = K_BR; alu = 4'b0000; src = 2'b00; end
      7'b1101111: begin cls = K_JAL; alu = 4'b0001; src = 2'b10; end
      default: cls = K_TRAP;
    endcase
  endfunction

  task automatic trap_and_reset();
    exp_t e;
    e = mk(3'd7);
    e.ill = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      noise(rb());
      step(e);
    end
    noise(rb());
    reset = 1'b1;
    step(e);
    reset = 1'b0;
    in_idle = 1'b1;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      noise(1'b0);
      step(mk(3'd5));
    end
  endtask

  // Issues one instruction: fw/mw are wait cycles before mem_ready in FETCH/MEM,
  // run_end is the run level at retirement, rst_mem asserts reset in that MEM cycle (-1: never).
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input bit z, input bit run_end, input int rst_mem);
    int         cls;
    logic [3:0] alu;
    logic [1:0] src;
    exp_t       e;
    bit         rdy;
    ref_decode(ins, cls, alu, src);

    if (in_idle) begin
      noise(1'b1);
      step(mk(3'd5));
      in_idle = 1'b0;
    end

    for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) begin
      drive(rb(), 1'b0, $urandom(), rb());
      e = mk(3'd0); e.mr = 1'b1;
      step(e);
    end
    if (fw >= MEM_TIMEOUT) begin
      trap_and_reset();
      return;
    end
    drive(rb(), 1'b1, ins, rb());
    e = mk(3'd0); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step(e);

    noise(rb());
    step(mk(3'd1));
    if (cls == K_TRAP) begin
      trap_and_reset();
      return;
    end

    drive((cls == K_BR) ? run_end : rb(), rb(), $urandom(), z);
    e = mk(3'd2); e.alu = alu; e.src = src;
    if (cls == K_BR) begin
      e.pcwc = ((ins[14:12] == 3'd0) && z) || ((ins[14:12] == 3'd1) && !z);
      e.ret  = 1'b1;
    end
    if (cls == K_JAL) e.pcwc = 1'b1;
    step(e);
    if (cls == K_BR) begin
      in_idle = !run_end;
      return;
    end

    if (cls == K_LD || cls == K_ST) begin
      for (int i = 0; ; i++) begin
        if (i == MEM_TIMEOUT) begin
          trap_and_reset();
          return;
        end
        rdy = (i == mw);
        e = mk(3'd3); e.alu = alu; e.src = src;
        e.mr  = (cls == K_LD);
        e.mw  = (cls == K_ST);
        e.ret = (cls == K_ST) && rdy;
        drive(((cls == K_ST) && rdy) ? run_end : rb(), rdy, $urandom(), rb());
        if (i == rst_mem) begin
          reset = 1'b1;
          step(e);
          reset = 1'b0;
          in_idle = 1'b1;
          return;
        end
        step(e);
        if (rdy) break;
      end
      if (cls == K_ST) begin
        in_idle = !run_end;
        return;
      end
    end

    drive(run_end, rb(), $urandom(), rb());
    e = mk(3'd4); e.alu = alu; e.src = src;
    e.rw = 1'b1; e.m2r = (cls == K_LD); e.ret = 1'b1;
    step(e);
    in_idle = !run_end;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    ins = $urandom();
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom());
    endcase
    case ($urandom_range(0, 8))
      0, 1: begin ins[6:0] = 7'b0110011; ins[31:25] = f7; end
      2, 3: begin ins[6:0] = 7'b0010011; ins[31:25] = f7; end
      4:    ins[6:0] = 7'b0000011;
      5:    ins[6:0] = 7'b0100011;
      6:    begin ins[6:0] = 7'b1100011; ins[14:12] = 3'($urandom_range(0, 2)); end
      7:    ins[6:0] = 7'b1101111;
      default: ;
    endcase
    return ins;
  endfunction

`ifdef MULTICYCLE_PERF_EN
  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask
`endif

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(mk(3'd5));
    reset = 1'b0;
    in_idle = 1'b1;

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b1, -1);  // add
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b1, -1);  // addi
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b1, -1);  // beq taken
    run_instr(32'h00208463, 1, 0, 1'b0, 1'b1, -1);  // beq not taken
    run_instr(32'h0000A283, 0, 3, 1'b0, 1'b1, -1);  // lw, 3 MEM waits
    run_instr(32'h0050A223, 0, 0, 1'b0, 1'b0, -1);  // sw, then IDLE
    idle_wait(2);
    run_instr(32'h0080006F, 2, 0, 1'b0, 1'b1, -1);  // jal
    run_instr(32'h40208133, 0, 0, 1'b0, 1'b1, -1);  // sub
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, -1);  // illegal opcode
    run_instr(32'h002081B3, MEM_TIMEOUT, 0, 1'b0, 1'b1, -1);  // fetch timeout
    run_instr(32'h0000A283, 0, 20, 1'b0, 1'b1, -1); // MEM timeout
    run_instr(32'h0000A283, 0, 5, 1'b0, 1'b1, 1);   // reset mid-MEM

`ifdef MULTICYCLE_PERF_EN
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b1, -1);
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, -1);
    check64("instret_cnt", instret_cnt, 64'd2);
    check64("cycle_cnt", cycle_cnt, 64'd7);
`endif

    for (int n = 0; n < 80; n++) begin
      if (in_idle && rb()) idle_wait($urandom_range(1, 2));
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                $urandom_range(0, 3) != 0, ($urandom_range(0, 19) == 0) ? 0 : -1);
    end

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never compared, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
